// File: rtl/nvme_regs_pkg.sv
// rtl/nvme_regs_pkg.sv - NVMe BAR0 register offsets, constants and RDY state type
package nvme_regs_pkg;

    localparam logic [12:0] OFF_CAP_LO = 13'h000;
    localparam logic [12:0] OFF_CAP_HI = 13'h004;
    localparam logic [12:0] OFF_VS     = 13'h008;
    localparam logic [12:0] OFF_CC     = 13'h014;
    localparam logic [12:0] OFF_CSTS   = 13'h01C;
    localparam logic [12:0] OFF_AQA    = 13'h024;
    localparam logic [12:0] OFF_ASQ_LO = 13'h028;
    localparam logic [12:0] OFF_ASQ_HI = 13'h02C;
    localparam logic [12:0] OFF_ACQ_LO = 13'h030;
    localparam logic [12:0] OFF_ACQ_HI = 13'h034;
    localparam logic [12:0] DB_BASE    = 13'h1000;

    localparam logic [31:0] CAP_LO_VAL = 32'h0101_00FF;
    localparam logic [31:0] CAP_HI_VAL = 32'h0000_0020;
    localparam logic [31:0] VS_VAL     = 32'h0001_0400;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        ENABLING,
        READY,
        DISABLING
    } rdy_state_t;

    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] wr_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? wr_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/nvme_ctrl_rdy_fsm.sv
// rtl/nvme_ctrl_rdy_fsm.sv - CSTS.RDY sequencer following CC.EN with a fixed delay
module nvme_ctrl_rdy_fsm
    import nvme_regs_pkg::*;
#(
    parameter int RDY_DELAY = 16
) (
    input  logic clk,
    input  logic rstn,
    input  logic cc_en,
    output logic csts_rdy,
    output logic disabling
);

    localparam int CW = (RDY_DELAY > 1) ? $clog2(RDY_DELAY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(RDY_DELAY - 1);

    rdy_state_t    state;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            csts_rdy  <= 1'b0;
            disabling <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cc_en) begin
                        state <= ENABLING;
                        cnt   <= CNT_LOAD;
                    end
                end
                ENABLING: begin
                    if (!cc_en) begin
                        state <= IDLE;
                    end else if (cnt == '0) begin
                        state    <= READY;
                        csts_rdy <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                READY: begin
                    if (!cc_en) begin
                        state     <= DISABLING;
                        cnt       <= CNT_LOAD;
                        disabling <= 1'b1;
                    end
                end
                DISABLING: begin
                    // A re-enable here is ignored; IDLE picks it up once shutdown completes.
                    if (cnt == '0) begin
                        state     <= IDLE;
                        csts_rdy  <= 1'b0;
                        disabling <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/nvme_ctrl_regs_slave.sv
// rtl/nvme_ctrl_regs_slave.sv - AXI4-Lite NVMe BAR0 register file with doorbell events
module nvme_ctrl_regs_slave
    import nvme_regs_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_QUEUES = 2,
    parameter int RDY_DELAY  = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [ADDR_WIDTH-1:0] s_awaddr,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [DATA_WIDTH-1:0] s_wdata,
    input  logic [3:0]            s_wstrb,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    output logic [1:0]            s_bresp,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    input  logic [ADDR_WIDTH-1:0] s_araddr,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    output logic [DATA_WIDTH-1:0] s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rvalid,
    input  logic                  s_rready,
    output logic                  db_valid,
    input  logic                  db_ready,
    output logic [3:0]            db_qid,
    output logic                  db_is_cq,
    output logic [15:0]           db_value,
    output logic                  cc_en,
    output logic                  csts_rdy,
    output logic [31:0]           aqa,
    output logic [63:0]           asq,
    output logic [63:0]           acq
);

    localparam logic [8:0] NQ = 9'(NUM_QUEUES);

    logic        live;
    logic        aw_held, w_held;
    logic [12:0] aw_addr;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic [31:0] cc_q, aqa_q, asq_lo, asq_hi, acq_lo, acq_hi;
    logic        disabling;

    logic        is_db, db_q_ok, db_bad, db_fire, slot_free, commit;
    logic [8:0]  db_q;
    logic [31:0] cc_nxt, rd_val;
    logic        unused_addr;

    assign unused_addr = ^{s_awaddr[ADDR_WIDTH-1:13], s_araddr[ADDR_WIDTH-1:13]};

    // Readys stay low through reset and the first cycle after it.
    assign s_awready = live && !aw_held;
    assign s_wready  = live && !w_held;
    assign s_arready = live && !s_rvalid;

    assign is_db     = aw_addr[12];
    assign db_q      = aw_addr[11:3];
    assign db_q_ok   = db_q < NQ;
    assign db_bad    = is_db && !db_q_ok;
    assign db_fire   = is_db && db_q_ok && csts_rdy && !disabling;
    assign slot_free = !db_valid || db_ready;
    assign commit    = aw_held && w_held && !s_bvalid && (!db_fire || slot_free);

    always_comb begin
        cc_nxt = cc_q;
        if (commit && aw_addr == OFF_CC) begin
            cc_nxt = apply_strb(cc_q, w_data, w_strb);
        end
    end

    // The FSM sees the post-commit EN so RDY moves exactly RDY_DELAY cycles after CC.EN does.
    nvme_ctrl_rdy_fsm #(.RDY_DELAY(RDY_DELAY)) u_rdy (
        .clk       (clk),
        .rstn      (rstn),
        .cc_en     (cc_nxt[0]),
        .csts_rdy  (csts_rdy),
        .disabling (disabling)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            live     <= 1'b0;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_addr  <= '0;
            w_data   <= '0;
            w_strb   <= '0;
            s_bvalid <= 1'b0;
            s_bresp  <= RESP_OKAY;
        end else begin
            live <= 1'b1;
            if (s_awvalid && s_awready) begin
                aw_held <= 1'b1;
                aw_addr <= s_awaddr[12:0];
            end
            if (s_wvalid && s_wready) begin
                w_held <= 1'b1;
                w_data <= s_wdata[31:0];
                w_strb <= s_wstrb;
            end
            if (commit) begin
                s_bvalid <= 1'b1;
                s_bresp  <= db_bad ? RESP_SLVERR : RESP_OKAY;
            end else if (s_bvalid && s_bready) begin
                s_bvalid <= 1'b0;
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cc_q   <= '0;
            aqa_q  <= '0;
            asq_lo <= '0;
            asq_hi <= '0;
            acq_lo <= '0;
            acq_hi <= '0;
        end else begin
            cc_q <= cc_nxt;
            if (commit) begin
                case (aw_addr)
                    OFF_AQA:    aqa_q  <= apply_strb(aqa_q, w_data, w_strb);
                    OFF_ASQ_LO: asq_lo <= apply_strb(asq_lo, w_data, w_strb) & 32'hFFFF_F000;
                    OFF_ASQ_HI: asq_hi <= apply_strb(asq_hi, w_data, w_strb);
                    OFF_ACQ_LO: acq_lo <= apply_strb(acq_lo, w_data, w_strb) & 32'hFFFF_F000;
                    OFF_ACQ_HI: acq_hi <= apply_strb(acq_hi, w_data, w_strb);
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            db_valid <= 1'b0;
            db_qid   <= '0;
            db_is_cq <= 1'b0;
            db_value <= '0;
        end else if (disabling) begin
            db_valid <= 1'b0;
        end else if (commit && db_fire) begin
            db_valid <= 1'b1;
            db_qid   <= db_q[3:0];
            db_is_cq <= aw_addr[2];
            db_value <= {w_strb[1] ? w_data[15:8] : 8'h00, w_strb[0] ? w_data[7:0] : 8'h00};
        end else if (db_valid && db_ready) begin
            db_valid <= 1'b0;
        end
    end

    always_comb begin
        rd_val = '0;
        case (s_araddr[12:0])
            OFF_CAP_LO: rd_val = CAP_LO_VAL;
            OFF_CAP_HI: rd_val = CAP_HI_VAL;
            OFF_VS:     rd_val = VS_VAL;
            OFF_CC:     rd_val = cc_q;
            OFF_CSTS:   rd_val = {31'b0, csts_rdy};
            OFF_AQA:    rd_val = aqa_q;
            OFF_ASQ_LO: rd_val = asq_lo;
            OFF_ASQ_HI: rd_val = asq_hi;
            OFF_ACQ_LO: rd_val = acq_lo;
            OFF_ACQ_HI: rd_val = acq_hi;
            default:    rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s_rvalid <= 1'b0;
            s_rdata  <= '0;
            s_rresp  <= RESP_OKAY;
        end else if (s_arvalid && s_arready) begin
            s_rvalid <= 1'b1;
            s_rdata  <= rd_val;
            s_rresp  <= RESP_OKAY;
        end else if (s_rvalid && s_rready) begin
            s_rvalid <= 1'b0;
        end
    end

    assign cc_en = cc_q[0];
    assign aqa   = aqa_q;
    assign asq   = {asq_hi, asq_lo};
    assign acq   = {acq_hi, acq_lo};

endmodule

// File: tb/tb_nvme_ctrl_regs_slave.sv
// tb/tb_nvme_ctrl_regs_slave.sv - scoreboard bench for nvme_ctrl_regs_slave
module tb_nvme_ctrl_regs_slave;
    import nvme_regs_pkg::*;

    localparam int RDY_DELAY  = 16;
    localparam int NUM_QUEUES = 2;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic [3:0]  s_wstrb;
    logic [1:0]  s_bresp, s_rresp;
    logic        db_valid, db_ready, db_is_cq, cc_en, csts_rdy;
    logic [3:0]  db_qid;
    logic [15:0] db_value;
    logic [31:0] aqa;
    logic [63:0] asq, acq;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } r_exp_t;

    r_exp_t      exp_r[$];
    logic [1:0]  exp_b[$];
    logic [20:0] exp_db[$];
    r_exp_t      r_pop;
    logic [20:0] db_pop;
    logic [1:0]  b_pop;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nvme_ctrl_regs_slave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_QUEUES(NUM_QUEUES), .RDY_DELAY(RDY_DELAY)
    ) dut (
        .clk(clk), .rstn(rstn),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .db_valid(db_valid), .db_ready(db_ready), .db_qid(db_qid), .db_is_cq(db_is_cq),
        .db_value(db_value), .cc_en(cc_en), .csts_rdy(csts_rdy),
        .aqa(aqa), .asq(asq), .acq(acq)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=event expected=none", name);
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (s_rvalid && s_rready) begin
                if (exp_r.size() == 0) fail("r_unexpected");
                else begin
                    r_pop = exp_r.pop_front();
                    check("rdata", s_rdata, r_pop.data);
                    check("rresp", s_rresp, r_pop.resp);
                end
            end
            if (s_bvalid && s_bready) begin
                if (exp_b.size() == 0) fail("b_unexpected");
                else begin
                    b_pop = exp_b.pop_front();
                    check("bresp", s_bresp, b_pop);
                end
            end
            if (db_valid && db_ready) begin
                if (exp_db.size() == 0) fail("db_unexpected");
                else begin
                    db_pop = exp_db.pop_front();
                    check("db_event", {db_qid, db_is_cq, db_value}, db_pop);
                end
            end
        end
    end

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] strb, input logic [1:0] resp);
        logic aw_hs, w_hs;
        exp_b.push_back(resp);
        s_awaddr = a; s_wdata = d; s_wstrb = strb;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        for (int i = 0; i < 100 && (s_awvalid || s_wvalid); i++) begin
            @(negedge clk);
            aw_hs = s_awvalid && s_awready;
            w_hs  = s_wvalid && s_wready;
            @(posedge clk); #1;
            if (aw_hs) s_awvalid = 1'b0;
            if (w_hs)  s_wvalid  = 1'b0;
        end
        if (s_awvalid || s_wvalid) begin
            s_awvalid = 1'b0; s_wvalid = 1'b0;
            fail("write_handshake_timeout");
        end
    endtask

    task automatic axi_read(input logic [31:0] a, input logic [31:0] d);
        logic  hs;
        r_exp_t e;
        hs = 1'b0;
        e.data = d; e.resp = RESP_OKAY;
        exp_r.push_back(e);
        s_araddr = a; s_arvalid = 1'b1;
        for (int i = 0; i < 50 && !hs; i++) begin
            @(negedge clk);
            hs = s_arready;
            @(posedge clk); #1;
        end
        s_arvalid = 1'b0;
        if (!hs) fail("read_handshake_timeout");
        else check("r_latency", s_rvalid, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (exp_b.size() + exp_r.size() + exp_db.size()) != 0; i++) begin
            @(posedge clk); #1;
        end
        if ((exp_b.size() + exp_r.size() + exp_db.size()) != 0) fail("drain_timeout");
    endtask

    task automatic measure_rdy(input logic target, input string nm);
        int n;
        for (int i = 0; i < 20 && cc_en !== target; i++) begin
            @(posedge clk); #1;
        end
        for (n = 0; n < 3 * RDY_DELAY && csts_rdy !== target; n++) begin
            @(posedge clk); #1;
        end
        check(nm, n, RDY_DELAY);
    endtask

    initial begin
        logic stable;
        int   rose;
        rstn = 1'b0;
        s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
        s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0; db_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ctrl", {s_awready, s_wready, s_arready, s_bvalid, s_rvalid,
                             db_valid, cc_en, csts_rdy, s_bresp, s_rresp}, 0);
        check("reset_rdata_aqa", {s_rdata, aqa}, 0);
        check("reset_asq", asq, 0);
        check("reset_acq", acq, 0);
        @(posedge clk); #1;
        rstn = 1'b1; s_rready = 1'b1; s_bready = 1'b1; db_ready = 1'b1;
        @(posedge clk); #1;

        axi_read(32'h00, 32'h0101_00FF);
        axi_read(32'h04, 32'h0000_0020);
        axi_read(32'h08, 32'h0001_0400);
        axi_read(32'h1C, 32'h0);
        axi_read(32'h40, 32'h0);
        drain();

        axi_write(32'h14, 32'h1, 4'hF, RESP_OKAY);
        measure_rdy(1'b1, "rdy_rise_delay");
        axi_read(32'h1C, 32'h1);
        axi_read(32'h14, 32'h1);
        drain();

        db_ready = 1'b0;
        exp_db.push_back({4'd0, 1'b0, 16'd7});
        exp_db.push_back({4'd1, 1'b1, 16'd3});
        axi_write(32'h1000, 32'd7, 4'hF, RESP_OKAY);
        axi_write(32'h100C, 32'd3, 4'hF, RESP_OKAY);
        repeat (6) begin @(posedge clk); #1; end
        check("db_stall_no_b", {s_bvalid, db_valid, 30'(exp_b.size())}, {1'b0, 1'b1, 30'd1});
        db_ready = 1'b1;
        drain();

        axi_write(32'h1010, 32'd9, 4'hF, RESP_SLVERR);
        axi_read(32'h1000, 32'h0);
        drain();

        axi_write(32'h14, 32'h0, 4'hF, RESP_OKAY);
        measure_rdy(1'b0, "rdy_fall_delay");
        axi_read(32'h1C, 32'h0);
        axi_write(32'h1000, 32'd5, 4'hF, RESP_OKAY);
        drain();

        axi_write(32'h14, 32'h1, 4'hF, RESP_OKAY);
        repeat (5) begin @(posedge clk); #1; end
        axi_write(32'h14, 32'h0, 4'hF, RESP_OKAY);
        rose = 0;
        for (int i = 0; i < 3 * RDY_DELAY; i++) begin
            @(posedge clk); #1;
            if (csts_rdy) rose++;
        end
        check("abort_no_rdy", rose, 0);
        check("abort_fsm_idle", dut.u_rdy.state, IDLE);
        drain();

        s_bready = 1'b0;
        exp_b.push_back(RESP_OKAY);
        s_wdata = 32'hFFFF_FFFF; s_wstrb = 4'b0011; s_wvalid = 1'b1;
        for (int i = 0; i < 20 && s_wvalid; i++) begin
            @(negedge clk);
            stable = s_wready;
            @(posedge clk); #1;
            if (stable) s_wvalid = 1'b0;
        end
        repeat (3) begin @(posedge clk); #1; end
        s_awaddr = 32'h28; s_awvalid = 1'b1;
        for (int i = 0; i < 20 && s_awvalid; i++) begin
            @(negedge clk);
            stable = s_awready;
            @(posedge clk); #1;
            if (stable) s_awvalid = 1'b0;
        end
        for (int i = 0; i < 10 && !s_bvalid; i++) begin
            @(posedge clk); #1;
        end
        stable = s_bvalid && (s_bresp == RESP_OKAY);
        repeat (4) begin
            @(posedge clk); #1;
            stable = stable && s_bvalid && (s_bresp == RESP_OKAY);
        end
        check("b_held_stable", stable, 1);
        s_bready = 1'b1;
        drain();
        axi_read(32'h28, 32'h0000_F000);
        check("asq_port", asq, 64'h0000_0000_0000_F000);

        axi_write(32'h24, 32'h1234_5678, 4'b0101, RESP_OKAY);
        axi_write(32'h30, 32'hABCD_E123, 4'hF, RESP_OKAY);
        axi_read(32'h24, 32'h0034_0078);
        axi_read(32'h30, 32'hABCD_E000);
        drain();

        check("queues_empty", exp_r.size() + exp_b.size() + exp_db.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
